// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use stalls, EX redirects,
// multi-cycle mul/div occupancy of EX and data-memory wait, plus a stall counter.
module hazard_stall_ctrl #(
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_md_start,
  input  logic             br_taken_ex,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             perf_clr,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned MD_CNT_W = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [MD_CNT_W-1:0] r_md_cnt;
  logic [MD_CNT_W-1:0] w_md_cnt_nxt;
  logic [CNT_W-1:0]    r_stall_cycles;
  logic                w_mem_stall;
  logic                w_load_use;

  assign w_mem_stall = mem_req & ~mem_ready;
  assign w_load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                        (id_use_rs2 && (id_rs2 == ex_rd)));

  // State and mul/div countdown registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state  <= RUN;
      r_md_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  // Prioritised hazard resolution; a data-memory wait freezes everything
  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    id_ex_we     = 1'b1;
    ex_mem_we    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    md_busy      = (r_state == MD_WAIT) && !Rst;

    if (Rst) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_we  = 1'b0;
      ex_mem_we = 1'b0;
    end else if (w_mem_stall) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_we  = 1'b0;
      ex_mem_we = 1'b0;
    end else if (r_state == MD_WAIT) begin
      if (r_md_cnt == '0) begin
        w_state_nxt = RUN;
      end else begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_ex_we     = 1'b0;
        ex_mem_flush = 1'b1;
        w_md_cnt_nxt = r_md_cnt - MD_CNT_W'(1);
      end
    end else if (br_taken_ex) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (ex_md_start) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_flush = 1'b1;
      w_state_nxt  = MD_WAIT;
      w_md_cnt_nxt = MD_CNT_W'(MD_LAT - 2);
    end else if (w_load_use) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // Saturating count of cycles in which the PC was held
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_stall_cycles <= '0;
    end else if (perf_clr) begin
      r_stall_cycles <= '0;
    end else if (!pc_we && !(&r_stall_cycles)) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed scoreboard bench for hazard_stall_ctrl (MD_LAT=4 main instance,
// MD_LAT=2 / 3-bit counter instance for short-latency and saturation cases).
module tb_hazard_stall_ctrl;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] exrd;
    logic       mrd;
    logic       md;
    logic       br;
    logic       mreq;
    logic       mrdy;
    logic       clr;
  } stim_t;

  // {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush, ex_mem_flush, md_busy}
  localparam logic [7:0] E_RST  = 8'b0000_0000;
  localparam logic [7:0] E_NORM = 8'b1111_0000;
  localparam logic [7:0] E_LU   = 8'b0011_0100;
  localparam logic [7:0] E_BR   = 8'b1111_1100;
  localparam logic [7:0] E_MDS  = 8'b0001_0010;
  localparam logic [7:0] E_MDW  = 8'b0001_0011;
  localparam logic [7:0] E_MDR  = 8'b1111_0001;
  localparam logic [7:0] E_MEMR = 8'b0000_0000;
  localparam logic [7:0] E_MEMW = 8'b0000_0001;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_mem_read = 1'b0;
  logic        ex_md_start = 1'b0, br_taken_ex = 1'b0;
  logic        mem_req = 1'b0, mem_ready = 1'b0, perf_clr = 1'b0;
  logic        pc_we, if_id_we, id_ex_we, ex_mem_we;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, md_busy;
  logic [15:0] stall_cycles;
  logic        b_pc_we, b_if_id_we, b_id_ex_we, b_ex_mem_we;
  logic        b_if_id_flush, b_id_ex_flush, b_ex_mem_flush, b_md_busy;
  logic [2:0]  b_stall_cycles;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          exp_stall = 0;
  logic [7:0]  sb_q[$];

  always #5 Clk = ~Clk;

  hazard_stall_ctrl #(.MD_LAT(4), .CNT_W(16)) u_dut (
    .Clk(Clk), .Rst(Rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_md_start(ex_md_start), .br_taken_ex(br_taken_ex),
    .mem_req(mem_req), .mem_ready(mem_ready), .perf_clr(perf_clr),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .md_busy(md_busy), .stall_cycles(stall_cycles)
  );

  hazard_stall_ctrl #(.MD_LAT(2), .CNT_W(3)) u_short (
    .Clk(Clk), .Rst(Rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_md_start(ex_md_start), .br_taken_ex(br_taken_ex),
    .mem_req(mem_req), .mem_ready(mem_ready), .perf_clr(perf_clr),
    .pc_we(b_pc_we), .if_id_we(b_if_id_we), .id_ex_we(b_id_ex_we), .ex_mem_we(b_ex_mem_we),
    .if_id_flush(b_if_id_flush), .id_ex_flush(b_id_ex_flush), .ex_mem_flush(b_ex_mem_flush),
    .md_busy(b_md_busy), .stall_cycles(b_stall_cycles)
  );

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t load_use(input logic on_rs1);
    stim_t s;
    s      = '0;
    s.exrd = 5'd5;
    s.mrd  = 1'b1;
    if (on_rs1) begin
      s.rs1 = 5'd5;
      s.u1  = 1'b1;
    end else begin
      s.rs2 = 5'd5;
      s.u2  = 1'b1;
    end
    return s;
  endfunction

  // Pop the expected vector for this cycle and compare with the main DUT
  task automatic check(input string tag, input logic rst, input logic clr);
    logic [7:0] obs;
    logic [7:0] exp;
    obs = {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush, ex_mem_flush, md_busy};
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s scoreboard empty observed=%b", tag, obs);
      exp = 8'hxx;
    end else begin
      exp = sb_q.pop_front();
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s ctrl observed=%b expected=%b", tag, obs, exp);
      end
    end
    if (rst) exp_stall = 0;
    n_cmp++;
    assert (stall_cycles === 16'(exp_stall)) else begin
      n_fail++;
      $error("FAIL %s stall_cycles observed=%0d expected=%0d", tag, stall_cycles, exp_stall);
    end
    if (rst || clr) exp_stall = 0;
    else if (exp[7] == 1'b0) exp_stall++;
  endtask

  task automatic step(input stim_t s, input logic [7:0] exp, input string tag);
    @(posedge Clk);
    #1;
    Rst = s.rst; id_rs1 = s.rs1; id_rs2 = s.rs2; id_use_rs1 = s.u1; id_use_rs2 = s.u2;
    ex_rd = s.exrd; ex_mem_read = s.mrd; ex_md_start = s.md; br_taken_ex = s.br;
    mem_req = s.mreq; mem_ready = s.mrdy; perf_clr = s.clr;
    sb_q.push_back(exp);
    @(negedge Clk);
    check(tag, s.rst, s.clr);
  endtask

  task automatic chk_short(input string tag, input logic [7:0] exp, input logic [2:0] exp_cnt);
    logic [7:0] obs;
    obs = {b_pc_we, b_if_id_we, b_id_ex_we, b_ex_mem_we,
           b_if_id_flush, b_id_ex_flush, b_ex_mem_flush, b_md_busy};
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s short ctrl observed=%b expected=%b", tag, obs, exp);
    end
    n_cmp++;
    assert (b_stall_cycles === exp_cnt) else begin
      n_fail++;
      $error("FAIL %s short stall_cycles observed=%0d expected=%0d", tag, b_stall_cycles, exp_cnt);
    end
  endtask

  initial begin
    stim_t s;

    s = idle(); s.rst = 1'b1;
    step(s, E_RST, "reset_hold");
    step(s, E_RST, "reset_hold2");
    step(idle(), E_NORM, "post_reset_idle");

    step(load_use(1'b0), E_LU, "load_use_rs2");
    step(idle(), E_NORM, "after_load_use");
    s = load_use(1'b0); s.exrd = 5'd0; s.rs2 = 5'd0;
    step(s, E_NORM, "load_rd_x0");
    s = load_use(1'b1); s.u1 = 1'b0;
    step(s, E_NORM, "rs1_match_unused");
    s = load_use(1'b0); s.mrd = 1'b0;
    step(s, E_NORM, "not_a_load");
    step(load_use(1'b1), E_LU, "load_use_rs1");
    s = load_use(1'b0); s.br = 1'b1;
    step(s, E_BR, "branch_over_load_use");
    s = idle(); s.br = 1'b1; s.md = 1'b1;
    step(s, E_BR, "branch_over_md_start");
    step(idle(), E_NORM, "after_branch");

    // mul/div, with redirect/load-use/start noise ignored while waiting
    s = idle(); s.md = 1'b1;
    step(s, E_MDS, "md_start");
    s = load_use(1'b0); s.br = 1'b1; s.md = 1'b1;
    step(s, E_MDW, "md_wait_cnt2_ignores");
    step(idle(), E_MDW, "md_wait_cnt1");
    step(idle(), E_MDR, "md_release");
    step(idle(), E_NORM, "after_md");

    // Memory wait parked on md_cnt==1
    s = idle(); s.md = 1'b1;
    step(s, E_MDS, "md2_start");
    step(idle(), E_MDW, "md2_wait_cnt2");
    s = idle(); s.mreq = 1'b1;
    for (int i = 0; i < 5; i++) step(s, E_MEMW, "mem_stall_in_md");
    s.mrdy = 1'b1;
    step(s, E_MDW, "md2_wait_cnt1_resume");
    step(idle(), E_MDR, "md2_release");
    step(idle(), E_NORM, "after_md2");

    // Memory wait in RUN beats branch and load-use
    s = load_use(1'b0); s.mreq = 1'b1;
    step(s, E_MEMR, "mem_stall_over_lu");
    s = idle(); s.br = 1'b1; s.md = 1'b1; s.mreq = 1'b1;
    step(s, E_MEMR, "mem_stall_over_br");
    s = idle(); s.mreq = 1'b1; s.mrdy = 1'b1;
    step(s, E_NORM, "mem_ready_same_cycle");

    // Clear wins over an increment in the same cycle
    s = load_use(1'b0); s.clr = 1'b1;
    step(s, E_LU, "perf_clr_with_stall");
    step(idle(), E_NORM, "after_clr");
    step(load_use(1'b1), E_LU, "count_after_clr");

    // Async reset in the middle of MD_WAIT
    s = idle(); s.md = 1'b1;
    step(s, E_MDS, "md3_start");
    step(idle(), E_MDW, "md3_wait");
    s = idle(); s.rst = 1'b1;
    step(s, E_RST, "reset_in_md_wait");
    step(idle(), E_NORM, "first_after_reset");
    chk_short("short_after_reset", E_NORM, 3'd0);

    // MD_LAT=2: one MD_WAIT cycle that releases; 3-bit counter saturates
    s = idle(); s.md = 1'b1;
    step(s, E_MDS, "md4_start");
    chk_short("short_md_start", E_MDS, 3'd0);
    step(idle(), E_MDW, "md4_wait_cnt2");
    chk_short("short_md_release", E_MDR, 3'd1);
    step(idle(), E_MDW, "md4_wait_cnt1");
    chk_short("short_after_md", E_NORM, 3'd1);
    step(idle(), E_MDR, "md4_release");
    for (int i = 0; i < 5; i++) step(load_use(1'b0), E_LU, "lu_burst");
    chk_short("short_lu5", E_LU, 3'd5);
    for (int i = 0; i < 5; i++) step(load_use(1'b1), E_LU, "lu_burst2");
    step(idle(), E_NORM, "final_idle");
    chk_short("short_saturated", E_NORM, 3'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
